// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage: instruction-fetch stage and IF/ID pipeline register.
//
// Holds the PC, drives the instruction-memory address, selects the next PC
// from the redirect sources and registers instruction, PC+4 and an interrupt
// tag into the IF/ID register consumed by decode.
//
// Ports:
//   clk            system clock
//   reset          synchronous active-low reset
//   oIMemAddr      instruction-memory address (current PC)
//   iIMemData      instruction word, combinational read of oIMemAddr
//   iStall         hold PC and IF/ID
//   iPCSrc         redirect select (0 = sequential)
//   iJumpIndex     J/JAL index field of the decode-stage instruction
//   iJumpBase      PC+4[31:28] of the decode-stage instruction
//   iJrTarget      register target for JR/JALR
//   iBranchTarget  taken-branch target from execute
//   iInterrupt     level interrupt request
//   oInstruction   IF/ID instruction
//   oPC_plus_4     IF/ID PC+4
//   oInterrupt     IF/ID interrupt tag
//   oStallCount    stalled-cycle counter (only with IF_STALL_CNT_EN)
//
// Optional feature: define IF_STALL_CNT_EN to add oStallCount.
// ---------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] RESET_PC   = 32'h8000_0000,
    parameter logic [31:0] IRQ_VECTOR = 32'h8000_0004,
    parameter logic [31:0] EXC_VECTOR = 32'h8000_0008,
    parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] oIMemAddr,
    input  logic [31:0] iIMemData,
    input  logic        iStall,
    input  logic [2:0]  iPCSrc,
    input  logic [25:0] iJumpIndex,
    input  logic [3:0]  iJumpBase,
    input  logic [31:0] iJrTarget,
    input  logic [31:0] iBranchTarget,
    input  logic        iInterrupt,
    output logic [31:0] oInstruction,
    output logic [31:0] oPC_plus_4,
    output logic        oInterrupt
`ifdef IF_STALL_CNT_EN
    ,
    output logic [31:0] oStallCount
`endif
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        irq_q, irq_d;
    logic        lockout_q, lockout_d;

    logic [31:0] pc_plus_4;
    logic [31:0] target;
    logic        redirect;
    logic        normal;
    logic        tag;

    // Bit 31 is the supervisor bit; sequential fetch never changes mode.
    assign pc_plus_4 = {pc_q[31], pc_q[30:0] + 31'd4};

    assign redirect = (iPCSrc != 3'd0);
    assign normal   = !redirect && !iStall;
    assign tag      = iInterrupt && !pc_q[31] && !lockout_q;

    always_comb begin
        target = pc_plus_4;
        unique case (iPCSrc)
            3'd1:    target = iBranchTarget;
            3'd2:    target = {iJumpBase, iJumpIndex, 2'b00};
            3'd3:    target = iJrTarget;
            3'd4:    target = IRQ_VECTOR;
            3'd5:    target = EXC_VECTOR;
            default: target = pc_plus_4;
        endcase
    end

    always_comb begin
        pc_d      = pc_q;
        instr_d   = instr_q;
        pc4_d     = pc4_q;
        irq_d     = irq_q;
        lockout_d = lockout_q;

        if (redirect) begin
            // Flush: the fetched word is discarded, even under stall.
            pc_d    = target;
            instr_d = NOP_WORD;
            pc4_d   = pc_plus_4;
            irq_d   = 1'b0;
        end else if (normal) begin
            pc_d    = pc_plus_4;
            instr_d = iIMemData;
            pc4_d   = pc_plus_4;
            irq_d   = tag;
            if (tag) begin
                lockout_d = 1'b1;
            end
        end

        // Servicing the interrupt re-arms tagging; clear beats set.
        if (iPCSrc == 3'd4) begin
            lockout_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q      <= RESET_PC;
            instr_q   <= NOP_WORD;
            pc4_q     <= RESET_PC + 32'd4;
            irq_q     <= 1'b0;
            lockout_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            pc4_q     <= pc4_d;
            irq_q     <= irq_d;
            lockout_q <= lockout_d;
        end
    end

    assign oIMemAddr    = pc_q;
    assign oInstruction = instr_q;
    assign oPC_plus_4   = pc4_q;
    assign oInterrupt   = irq_q;

`ifdef IF_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_q <= 32'd0;
        end else if (iStall && !redirect) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign oStallCount = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        stall;
    logic [2:0]  pc_src;
    logic [25:0] jump_index;
    logic [3:0]  jump_base;
    logic [31:0] jr_target;
    logic [31:0] branch_target;
    logic        irq;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        irq_tag;
`ifdef IF_STALL_CNT_EN
    logic [31:0] stall_count;
`endif

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    // Memory model: each word is a fixed function of its address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1234_5678;
    endfunction

    assign imem_data = mem_word(imem_addr);

    if_stage dut (
        .clk          (clk),
        .reset        (reset),
        .oIMemAddr    (imem_addr),
        .iIMemData    (imem_data),
        .iStall       (stall),
        .iPCSrc       (pc_src),
        .iJumpIndex   (jump_index),
        .iJumpBase    (jump_base),
        .iJrTarget    (jr_target),
        .iBranchTarget(branch_target),
        .iInterrupt   (irq),
        .oInstruction (instr),
        .oPC_plus_4   (pc4),
        .oInterrupt   (irq_tag)
`ifdef IF_STALL_CNT_EN
        ,
        .oStallCount  (stall_count)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; stall = 1'b0; pc_src = 3'd0; irq = 1'b0;
        jump_index = '0; jump_base = '0; jr_target = '0; branch_target = '0;
        step(); step();
        total++; if (imem_addr !== 32'h8000_0000) $display("FAIL reset_pc got %h want 80000000", imem_addr); else passed++;
        total++; if (instr !== 32'h0) $display("FAIL reset_instr got %h want 0", instr); else passed++;
        total++; if (pc4 !== 32'h8000_0004) $display("FAIL reset_pc4 got %h want 80000004", pc4); else passed++;
        total++; if (irq_tag !== 1'b0) $display("FAIL reset_irq got %b want 0", irq_tag); else passed++;
        reset = 1'b1;
    endtask

    task automatic test_free_run();
        logic [31:0] pc;
        pc = 32'h8000_0000;
        for (int i = 0; i < 4; i++) begin
            step();
            total++; if (imem_addr !== pc + 32'd4) $display("FAIL run_pc[%0d] got %h want %h", i, imem_addr, pc + 32'd4); else passed++;
            total++; if (instr !== mem_word(pc)) $display("FAIL run_instr[%0d] got %h want %h", i, instr, mem_word(pc)); else passed++;
            total++; if (pc4 !== pc + 32'd4) $display("FAIL run_pc4[%0d] got %h want %h", i, pc4, pc + 32'd4); else passed++;
            pc = pc + 32'd4;
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (imem_addr !== 32'h8000_0010) $display("FAIL stall_pc[%0d] got %h want 80000010", i, imem_addr); else passed++;
            total++; if (instr !== mem_word(32'h8000_000C)) $display("FAIL stall_instr[%0d] got %h want %h", i, instr, mem_word(32'h8000_000C)); else passed++;
            total++; if (pc4 !== 32'h8000_0010) $display("FAIL stall_pc4[%0d] got %h want 80000010", i, pc4); else passed++;
        end
`ifdef IF_STALL_CNT_EN
        total++; if (stall_count !== 32'd3) $display("FAIL stall_count got %0d want 3", stall_count); else passed++;
`endif
        stall = 1'b0;
        step();
        total++; if (imem_addr !== 32'h8000_0014) $display("FAIL stall_resume_pc got %h want 80000014", imem_addr); else passed++;
        total++; if (instr !== mem_word(32'h8000_0010)) $display("FAIL stall_resume_instr got %h want %h", instr, mem_word(32'h8000_0010)); else passed++;
    endtask

    task automatic test_redirects();
        // Branch under stall: redirect wins and flushes.
        stall = 1'b1; pc_src = 3'd1; branch_target = 32'h0000_0100;
        step();
        total++; if (imem_addr !== 32'h0000_0100) $display("FAIL branch_pc got %h want 00000100", imem_addr); else passed++;
        total++; if (instr !== 32'h0) $display("FAIL branch_flush got %h want 0", instr); else passed++;
        total++; if (irq_tag !== 1'b0) $display("FAIL branch_irq got %b want 0", irq_tag); else passed++;
`ifdef IF_STALL_CNT_EN
        total++; if (stall_count !== 32'd3) $display("FAIL stall_count_redirect got %0d want 3", stall_count); else passed++;
`endif
        stall = 1'b0; pc_src = 3'd0;
        step();
        total++; if (imem_addr !== 32'h0000_0104) $display("FAIL seq_pc got %h want 00000104", imem_addr); else passed++;
        // Jump back to 0x100.
        pc_src = 3'd2; jump_base = 4'h0; jump_index = 26'h000_0040;
        step();
        total++; if (imem_addr !== 32'h0000_0100) $display("FAIL jump_pc got %h want 00000100", imem_addr); else passed++;
        total++; if (instr !== 32'h0) $display("FAIL jump_flush got %h want 0", instr); else passed++;
        jump_base = 4'h1; jump_index = 26'h000_0080;
        step();
        total++; if (imem_addr !== 32'h1000_0200) $display("FAIL jump_base_pc got %h want 10000200", imem_addr); else passed++;
        pc_src = 3'd5;
        step();
        total++; if (imem_addr !== 32'h8000_0008) $display("FAIL exc_pc got %h want 80000008", imem_addr); else passed++;
        pc_src = 3'd6;
        step();
        total++; if (imem_addr !== 32'h8000_000C) $display("FAIL src6_pc got %h want 8000000c", imem_addr); else passed++;
        total++; if (instr !== 32'h0) $display("FAIL src6_flush got %h want 0", instr); else passed++;
        pc_src = 3'd3; jr_target = 32'h0000_0200;
        step();
        total++; if (imem_addr !== 32'h0000_0200) $display("FAIL jr_pc got %h want 00000200", imem_addr); else passed++;
        pc_src = 3'd0;
    endtask

    task automatic test_interrupt();
        logic [3:0] tags;
        irq = 1'b1;
        tags = '0;
        for (int i = 0; i < 4; i++) begin
            step();
            tags[i] = irq_tag;
            if (i == 0) begin
                total++; if (pc4 !== 32'h0000_0204) $display("FAIL irq_pc4 got %h want 00000204", pc4); else passed++;
            end
        end
        total++; if (tags !== 4'b0001) $display("FAIL irq_once got %b want 0001", tags); else passed++;
        pc_src = 3'd4;
        step();
        total++; if (imem_addr !== 32'h8000_0004) $display("FAIL irq_vec_pc got %h want 80000004", imem_addr); else passed++;
        total++; if (irq_tag !== 1'b0) $display("FAIL irq_vec_tag got %b want 0", irq_tag); else passed++;
        // Kernel mode: request held but never tagged.
        pc_src = 3'd3; jr_target = 32'h8000_0020;
        step();
        pc_src = 3'd0;
        step();
        total++; if (irq_tag !== 1'b0) $display("FAIL kernel_tag0 got %b want 0", irq_tag); else passed++;
        total++; if (instr !== mem_word(32'h8000_0020)) $display("FAIL kernel_instr got %h want %h", instr, mem_word(32'h8000_0020)); else passed++;
        step();
        total++; if (irq_tag !== 1'b0) $display("FAIL kernel_tag1 got %b want 0", irq_tag); else passed++;
        // Return to user: first fetch is tagged, the next is not.
        pc_src = 3'd3; jr_target = 32'h0000_0300;
        step();
        total++; if (irq_tag !== 1'b0) $display("FAIL exit_flush_tag got %b want 0", irq_tag); else passed++;
        pc_src = 3'd0;
        step();
        total++; if (irq_tag !== 1'b1) $display("FAIL user_tag got %b want 1", irq_tag); else passed++;
        total++; if (pc4 !== 32'h0000_0304) $display("FAIL user_tag_pc4 got %h want 00000304", pc4); else passed++;
        step();
        total++; if (irq_tag !== 1'b0) $display("FAIL user_lockout got %b want 0", irq_tag); else passed++;
        irq = 1'b0;
    endtask

    task automatic test_wrap();
        pc_src = 3'd3; jr_target = 32'hFFFF_FFFC;
        step();
        pc_src = 3'd0;
        step();
        total++; if (imem_addr !== 32'h8000_0000) $display("FAIL wrap_kernel_pc got %h want 80000000", imem_addr); else passed++;
        total++; if (pc4 !== 32'h8000_0000) $display("FAIL wrap_kernel_pc4 got %h want 80000000", pc4); else passed++;
        pc_src = 3'd3; jr_target = 32'h7FFF_FFFC;
        step();
        pc_src = 3'd0;
        step();
        total++; if (imem_addr !== 32'h0000_0000) $display("FAIL wrap_user_pc got %h want 00000000", imem_addr); else passed++;
    endtask

    task automatic test_reset_override();
        // Lockout is still set from the 0x300 tag; reset must clear it.
        reset = 1'b0; stall = 1'b1; pc_src = 3'd1; branch_target = 32'h0000_0500;
        step();
        total++; if (imem_addr !== 32'h8000_0000) $display("FAIL rst_ovr_pc got %h want 80000000", imem_addr); else passed++;
        total++; if (pc4 !== 32'h8000_0004) $display("FAIL rst_ovr_pc4 got %h want 80000004", pc4); else passed++;
        total++; if (instr !== 32'h0) $display("FAIL rst_ovr_instr got %h want 0", instr); else passed++;
`ifdef IF_STALL_CNT_EN
        total++; if (stall_count !== 32'd0) $display("FAIL rst_ovr_count got %0d want 0", stall_count); else passed++;
`endif
        reset = 1'b1; stall = 1'b0; irq = 1'b1;
        pc_src = 3'd3; jr_target = 32'h0000_0400;
        step();
        pc_src = 3'd0;
        step();
        total++; if (irq_tag !== 1'b1) $display("FAIL rst_lockout_clear got %b want 1", irq_tag); else passed++;
        irq = 1'b0;
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_stall();
        test_redirects();
        test_interrupt();
        test_wrap();
        test_reset_override();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
